// File: rtl/alu_pkg.sv
// Shared encodings for the sequential ALU: opcodes, NZCV bit positions, FSM states.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_ADC = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_SBC = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    localparam int unsigned ST_W    = 1;
    localparam logic [0:0]  ST_IDLE = 1'b0;
    localparam logic [0:0]  ST_MUL  = 1'b1;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier: one partial product per cycle for WIDTH cycles.
// done/product are presented during the final iteration so the caller can capture on that edge.
module alu_mul_seq #(
    parameter int unsigned WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam int unsigned PW    = 2 * WIDTH;

    logic             r_busy;
    logic [CNT_W-1:0] r_cnt;
    logic [PW-1:0]    r_acc;
    logic [PW-1:0]    r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [PW-1:0]    w_acc_nxt;
    logic             w_last;

    assign w_acc_nxt = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else if (start) begin
            r_busy   <= 1'b1;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= PW'(a);
            r_mplier <= b;
        end else if (r_busy) begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign busy    = r_busy;
    assign done    = r_busy && w_last;
    assign product = w_acc_nxt;

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with NZCV flag register, valid/ready handshake and optional multi-cycle MUL.
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter bit          MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    input  logic             flag_wr,
    input  logic [3:0]       flag_wdata
);

    localparam int unsigned MSB   = WIDTH - 1;
    localparam int unsigned SUM_W = WIDTH + 1;

    logic [ST_W-1:0]    r_state;
    logic [ST_W-1:0]    w_state_nxt;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_result;
    logic [3:0]         r_flags;

    logic               w_out_valid_nxt;
    logic [WIDTH-1:0]   w_result_nxt;
    logic [3:0]         w_flags_nxt;
    logic               w_accept;
    logic               w_is_mul;
    logic               w_mul_start;
    logic               w_mul_busy;
    logic               w_mul_done;
    logic [2*WIDTH-1:0] w_product;
    logic [3:0]         w_mul_flags;

    logic [WIDTH-1:0]   w_addend;
    logic               w_cin;
    logic [SUM_W-1:0]   w_sum;
    logic [WIDTH-1:0]   w_alu_res;
    logic [3:0]         w_alu_flags;

    assign in_ready = (r_state == ST_IDLE) && (!r_out_valid || out_ready);
    assign w_accept = in_valid && in_ready;
    assign w_is_mul = MUL_EN && (op == OP_MUL);

    // Single-cycle add/logic path; carry-in comes from the flag register as it stands now.
    always_comb begin
        w_addend    = b;
        w_cin       = 1'b0;
        w_alu_res   = '0;
        w_alu_flags = r_flags;
        case (op)
            OP_ADC:  w_cin = r_flags[FLAG_C];
            OP_SUB:  begin w_addend = ~b; w_cin = 1'b1;           end
            OP_SBC:  begin w_addend = ~b; w_cin = r_flags[FLAG_C]; end
            default: ;
        endcase
        w_sum = {1'b0, a} + {1'b0, w_addend} + SUM_W'(w_cin);
        case (op)
            OP_AND:  w_alu_res = a & b;
            OP_OR:   w_alu_res = a | b;
            OP_XOR:  w_alu_res = a ^ b;
            default: begin
                w_alu_res           = w_sum[WIDTH-1:0];
                w_alu_flags[FLAG_C] = w_sum[WIDTH];
                w_alu_flags[FLAG_V] = (a[MSB] == w_addend[MSB]) && (w_alu_res[MSB] != a[MSB]);
            end
        endcase
        w_alu_flags[FLAG_N] = w_alu_res[MSB];
        w_alu_flags[FLAG_Z] = (w_alu_res == '0);
    end

    always_comb begin
        w_mul_flags         = 4'b0000;
        w_mul_flags[FLAG_N] = w_product[MSB];
        w_mul_flags[FLAG_Z] = (w_product[WIDTH-1:0] == '0);
        w_mul_flags[FLAG_C] = |w_product[2*WIDTH-1:WIDTH];
    end

    if (MUL_EN) begin : g_mul
        alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
            .clk     (clk),
            .rst_n   (rst_n),
            .start   (w_mul_start),
            .a       (a),
            .b       (b),
            .busy    (w_mul_busy),
            .done    (w_mul_done),
            .product (w_product)
        );
    end else begin : g_no_mul
        logic w_unused_start;
        assign w_unused_start = w_mul_start;
        assign w_mul_busy     = 1'b0;
        assign w_mul_done     = 1'b0;
        assign w_product      = '0;
    end

    // Next-state and output-register update; a result write takes priority over flag_wr.
    always_comb begin
        w_state_nxt     = r_state;
        w_result_nxt    = r_result;
        w_flags_nxt     = flag_wr ? flag_wdata : r_flags;
        w_out_valid_nxt = r_out_valid && !out_ready;
        w_mul_start     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_is_mul) begin
                        w_mul_start = 1'b1;
                        w_state_nxt = ST_MUL;
                    end else begin
                        w_result_nxt    = w_alu_res;
                        w_flags_nxt     = w_alu_flags;
                        w_out_valid_nxt = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                if (w_mul_done) begin
                    w_result_nxt    = w_product[WIDTH-1:0];
                    w_flags_nxt     = w_mul_flags;
                    w_out_valid_nxt = 1'b1;
                    w_state_nxt     = ST_IDLE;
                end else if (!w_mul_busy) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_flags     <= 4'b0000;
        end else begin
            r_state     <= w_state_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_result    <= w_result_nxt;
            r_flags     <= w_flags_nxt;
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign flags     = r_flags;

endmodule
